fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of decode and immediate generation. Holds the PC and issues one word request at a time to instruction memory over a valid/ready interface. Presents each returned word with its PC to decode through a one-entry output buffer. Redirects on taken branches using the sign-extended B-type immediate (`ImmOp`) produced downstream.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/pc_target.sv | 10 +
 rtl/fetch_unit.sv | 89 ++++++++
 tb/tb_fetch_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;
    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DRAIN
    } fetch_state_t;
endpackage

// File: rtl/pc_target.sv
// rtl/pc_target.sv - word-aligned branch target adder (branch pc + sign-extended offset)
module pc_target
    import fetch_pkg::*;
(
    input  logic [XLEN-1:0] branchPc,
    input  logic [XLEN-1:0] immOp,
    output logic [XLEN-1:0] targetPc
);
    assign targetPc = (branchPc + immOp) & ~XLEN'(INSTR_BYTES - 1);
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: pc register, single-outstanding memory requests,
// one-entry output buffer to decode and taken-branch redirect
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        PCsrc,
    input  logic [31:0] branch_pc,
    input  logic [31:0] ImmOp
);
    fetch_state_t    state;
    fetch_state_t    nextState;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] targetPc;
    logic            capture;

    pc_target uTarget (
        .branchPc (branch_pc),
        .immOp    (ImmOp),
        .targetPc (targetPc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // A redirect must never let an in-flight response reach the buffer, so any
    // outstanding request forces a pass through DRAIN before refetching.
    always_comb begin
        nextState = state;
        if (PCsrc) begin
            case (state)
                REQ:     nextState = imem_req_ready ? DRAIN : REQ;
                WAIT:    nextState = imem_rsp_valid ? REQ : DRAIN;
                DRAIN:   nextState = imem_rsp_valid ? REQ : DRAIN;
                default: nextState = REQ;
            endcase
        end else begin
            case (state)
                IDLE:    nextState = REQ;
                REQ:     nextState = imem_req_ready ? WAIT : REQ;
                WAIT:    nextState = imem_rsp_valid ? HOLD : WAIT;
                HOLD:    nextState = instr_ready ? REQ : HOLD;
                DRAIN:   nextState = imem_rsp_valid ? REQ : DRAIN;
                default: nextState = IDLE;
            endcase
        end
    end

    assign capture = (state == WAIT) && imem_rsp_valid && !PCsrc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            instr    <= '0;
            instr_pc <= '0;
        end else begin
            if (PCsrc) begin
                pc <= targetPc;
            end else if (capture) begin
                pc <= pc + XLEN'(INSTR_BYTES);
            end
            if (capture) begin
                instr    <= imem_rsp_data;
                instr_pc <= pc;
            end
        end
    end

    assign imem_req_valid = (state == REQ);
    assign instr_valid    = (state == HOLD);
    assign imem_addr      = pc;
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed plan checks plus randomized scoreboard bench for fetch_unit
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        PCsrc;
    logic [31:0] branch_pc;
    logic [31:0] ImmOp;

    logic        wReqValid;
    logic [31:0] wAddr;
    logic        wInstrValid;
    logic [31:0] wInstr;
    logic [31:0] wInstrPc;

    int          checks = 0;
    int          errors = 0;
    int          delivered = 0;
    int          idleCycles = 0;
    logic        sbEn = 1'b0;
    logic [31:0] expQ[$];
    logic [31:0] sbExp;

    logic        pendValid = 1'b0;
    logic [31:0] pendAddr = '0;
    int          pendLat = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .PCsrc          (PCsrc),
        .branch_pc      (branch_pc),
        .ImmOp          (ImmOp)
    );

    // Second instance at the top of the address space, memory always ready and responding.
    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dutWrap (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (wReqValid),
        .imem_req_ready (1'b1),
        .imem_addr      (wAddr),
        .imem_rsp_valid (1'b1),
        .imem_rsp_data  (32'h0000_0013),
        .instr_valid    (wInstrValid),
        .instr_ready    (1'b0),
        .instr          (wInstr),
        .instr_pc       (wInstrPc),
        .PCsrc          (1'b0),
        .branch_pc      (32'h0),
        .ImmOp          (32'h0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0050_0093 : ((a * 32'h9E37_79B1) ^ 32'h0F0F_1234);
    endfunction

    task automatic waitReq(input string name);
        int n = 0;
        while (!imem_req_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(imem_req_valid), 32'd1);
    endtask

    task automatic fetchWord(input logic [31:0] data);
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
    endtask

    // Memory model: random ready, 1..4 cycle response latency, occasional stray responses.
    task automatic memStep();
        logic busy;
        busy = pendValid;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (pendValid) begin
            if (pendLat == 0) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = memWord(pendAddr);
                pendValid      = 1'b0;
            end else begin
                pendLat--;
            end
        end else if ($urandom_range(7) == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hBAD0_0000 ^ 32'($urandom_range(16'hFFFF));
        end
        imem_req_ready = ($urandom_range(1) == 1);
        if (imem_req_valid) begin
            check("one_outstanding", 32'(busy), 32'd0);
            check("req_aligned", 32'(imem_addr[1:0]), 32'd0);
            if (imem_req_ready) begin
                pendValid = 1'b1;
                pendAddr  = imem_addr;
                pendLat   = $urandom_range(3);
            end
        end
    endtask

    // Scoreboard: head of expQ is the next instruction decode must receive.
    always @(negedge clk) begin
        #1;
        if (sbEn) begin
            if (instr_valid && instr_ready) begin
                sbExp = expQ.pop_front();
                check("sb_instr_pc", instr_pc, sbExp);
                check("sb_instr", instr, memWord(sbExp));
                expQ.push_back(sbExp + 32'd4);
                delivered++;
                idleCycles = 0;
            end else begin
                idleCycles++;
                if (idleCycles > 200) begin
                    check("sb_progress_timeout", 32'(idleCycles), 32'd0);
                    idleCycles = 0;
                end
            end
            if (PCsrc) begin
                expQ.delete();
                expQ.push_back((branch_pc + ImmOp) & 32'hFFFF_FFFC);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        instr_ready = 1'b0;
        PCsrc = 1'b0;
        branch_pc = '0;
        ImmOp = '0;
        repeat (2) @(negedge clk);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("wrap_rst_addr", wAddr, 32'hFFFF_FFFC);

        rst_n = 1'b1;
        #1;
        check("idle_no_req", 32'(imem_req_valid), 32'd0);
        waitReq("first_req");
        check("first_addr", imem_addr, 32'h0);
        fetchWord(32'h0050_0093);
        check("first_instr_valid", 32'(instr_valid), 32'd1);
        check("first_instr", instr, 32'h0050_0093);
        check("first_instr_pc", instr_pc, 32'h0);

        check("wrap_instr_valid", 32'(wInstrValid), 32'd1);
        check("wrap_instr_pc", wInstrPc, 32'hFFFF_FFFC);
        check("wrap_instr", wInstr, 32'h0000_0013);
        check("wrap_next_addr", wAddr, 32'h0);
        check("wrap_no_req", 32'(wReqValid), 32'd0);

        for (int i = 0; i < 5; i++) begin
            check("bp_instr", instr, 32'h0050_0093);
            check("bp_instr_pc", instr_pc, 32'h0);
            check("bp_no_req", 32'(imem_req_valid), 32'd0);
            @(negedge clk);
        end
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        check("bp_next_req", 32'(imem_req_valid), 32'd1);
        check("bp_next_addr", imem_addr, 32'h4);

        fetchWord(32'h1111_1111);
        check("hold_instr_pc", instr_pc, 32'h4);
        PCsrc = 1'b1;
        branch_pc = 32'h10;
        ImmOp = 32'hFFFF_FFF8;
        @(negedge clk);
        PCsrc = 1'b0;
        check("redir_hold_valid_drop", 32'(instr_valid), 32'd0);
        check("redir_hold_req", 32'(imem_req_valid), 32'd1);
        check("redir_hold_addr", imem_addr, 32'h8);

        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        PCsrc = 1'b1;
        branch_pc = 32'h100;
        ImmOp = 32'h20;
        @(negedge clk);
        PCsrc = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data = 32'hDEAD_BEEF;
        check("drain_no_req", 32'(imem_req_valid), 32'd0);
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        check("redir_wait_req", 32'(imem_req_valid), 32'd1);
        check("redir_wait_addr", imem_addr, 32'h120);
        check("redir_wait_no_valid", 32'(instr_valid), 32'd0);
        check("redir_wait_instr_kept", instr, 32'h1111_1111);
        fetchWord(32'h2222_2222);
        check("after_drain_instr", instr, 32'h2222_2222);
        check("after_drain_pc", instr_pc, 32'h120);
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        check("after_drain_next_addr", imem_addr, 32'h124);

        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_req_valid", 32'(imem_req_valid), 32'd0);
        check("midrst_addr", imem_addr, 32'h0);
        check("midrst_instr_valid", 32'(instr_valid), 32'd0);
        check("midrst_instr", instr, 32'h0);
        check("midrst_instr_pc", instr_pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        check("midrst_first_req", 32'(imem_req_valid), 32'd1);
        check("midrst_first_addr", imem_addr, 32'h0);
        check("midrst_stale_ignored", instr, 32'h0);

        expQ.delete();
        expQ.push_back(32'h0);
        sbEn = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            memStep();
            instr_ready = ($urandom_range(2) != 0);
            PCsrc = ($urandom_range(9) == 0);
            branch_pc = $urandom;
            ImmOp = $urandom;
        end
        @(negedge clk);
        sbEn = 1'b0;
        PCsrc = 1'b0;
        check("sb_min_deliveries", 32'(delivered >= 50), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
